if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the RV32I pipeline: PC register, sequential next-PC (pc+4), branch/jump
//  redirect, load-use stall, halt, and the IF/ID pipeline register. Drives the instruction-memory
//  address and the pc/pc+4 values consumed by the ID stage and the branch-target adder downstream.
// PARAMETERS
//  XLEN      32            datapath/address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  NOP_INSTR 32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     synchronous reset, active-high
//  stall         in   1     hazard unit: hold PC and IF/ID
//  branch_taken  in   1     EX stage: redirect fetch, flush IF/ID
//  branch_target in   XLEN  redirect address (bits [1:0] ignored)
//  halt_req      in   1     ID stage: ecall/ebreak decoded, stop fetching
//  imem_addr     out  XLEN  current PC to instruction memory (= pc register)
//  imem_rdata    in   32    instruction at imem_addr, combinational read
//  ifid_pc       out  XLEN  PC of instruction in IF/ID
//  ifid_pc4      out  XLEN  ifid_pc + 4 (link address for jal/jalr)
//  ifid_instr    out  32    instruction in IF/ID
//  ifid_valid    out  1     IF/ID holds a real instruction (0 = bubble)
//  halted        out  1     FSM in HALTED
//  fetch_count   out  32    number of valid instructions loaded into IF/ID
// BEHAVIOUR
//  - All state updates on posedge clk; no combinational path from inputs to registered outputs.
//  - Reset (rst=1, overrides everything, mid-operation included): pc=RESET_PC, ifid_pc=0, ifid_pc4=0,
//    ifid_instr=NOP_INSTR, ifid_valid=0, state=RUN, halted=0, fetch_count=0.
//  - FSM: RUN, HALTED. RUN->HALTED on halt_req when branch_taken=0. HALTED exits only via rst.
//  - Priority per cycle in RUN: branch_taken > halt_req > stall > normal.
//    * normal: IF/ID <= {pc, pc+4, imem_rdata, valid=1}; pc <= pc+4; fetch_count++.
//    * stall: pc and all IF/ID outputs hold; fetch_count holds.
//    * halt_req: pc holds; IF/ID <= bubble {ifid_pc/pc4 hold, NOP_INSTR, valid=0}; state<=HALTED.
//    * branch_taken: pc <= {branch_target[XLEN-1:2],2'b00}; IF/ID <= bubble. Overrides stall
//      (wrong-path instruction must be flushed) and halt_req (halting instr is on the wrong path).
//  - HALTED: pc and IF/ID frozen (valid=0); stall, branch_taken, halt_req ignored; halted=1.
//  - Latency: instruction at address A appears on ifid_instr one cycle after imem_addr==A.
//  - Arithmetic: pc+4 modulo 2^XLEN (FFFF_FFFC -> 0000_0000, no flag); fetch_count wraps at 2^32.
//  - pc[1:0] is always 2'b00.
// TESTING
//  1 rst 2 cycles, release, imem returns A+0x100 -> ifid_pc 0,4,8; ifid_instr 0x100,0x104,0x108; valid=1.
//  2 stall high 3 cycles at pc=0x8 -> imem_addr=0x8, IF/ID, fetch_count all frozen; resume at 0x8.
//  3 branch_taken with target 0x43 while stall=1 -> next pc=0x40, ifid_valid=0, ifid_instr=0x13.
//  4 halt_req at pc=0x10 -> halted=1 next cycle, pc stays 0x10, valid=0; later branch_taken ignored.
//  5 halt_req and branch_taken same cycle, target 0x80 -> halted=0, pc=0x80, IF/ID bubble.
//  6 pc preset near top (RESET_PC=FFFF_FFF8) -> pc FFFF_FFFC then 0; rst mid-run -> all reset values.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the RV32I pipeline: PC register, pc+4 sequencing, branch redirect,
// stall and halt handling, and the IF/ID pipeline register.
module if_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            halt_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            halted,
    output logic [31:0]     fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Word alignment: the low two address bits are forced to zero everywhere pc is loaded.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;

    assign pc_plus4    = pc + XLEN'(4);
    assign redirect_pc = branch_target & ALIGN_MASK;
    assign imem_addr   = pc;

    // Priority in RUN: branch_taken > halt_req > stall > sequential fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            halted      <= 1'b0;
            pc          <= RESET_PC & ALIGN_MASK;
            ifid_pc     <= '0;
            ifid_pc4    <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (state == RUN) begin
            if (branch_taken) begin
                // The instruction fetched this cycle is on the wrong path, so flush it.
                pc         <= redirect_pc;
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else if (halt_req) begin
                state      <= HALTED;
                halted     <= 1'b1;
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                pc          <= pc_plus4;
                ifid_pc     <= pc;
                ifid_pc4    <= pc_plus4;
                ifid_instr  <= imem_rdata;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal checks plus a randomized
// phase, two instances (reset PC 0 and near the top of memory) compared each cycle against a model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt_req = 1'b0;

    logic [31:0] imem_addr   [2];
    logic [31:0] imem_rdata  [2];
    logic [31:0] ifid_pc     [2];
    logic [31:0] ifid_pc4    [2];
    logic [31:0] ifid_instr  [2];
    logic        ifid_valid  [2];
    logic        halted      [2];
    logic [31:0] fetch_count [2];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Instruction memory: the word at address A reads as A + 0x100.
    assign imem_rdata[0] = imem_addr[0] + 32'h100;
    assign imem_rdata[1] = imem_addr[1] + 32'h100;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .imem_addr(imem_addr[0]),
        .imem_rdata(imem_rdata[0]), .ifid_pc(ifid_pc[0]), .ifid_pc4(ifid_pc4[0]),
        .ifid_instr(ifid_instr[0]), .ifid_valid(ifid_valid[0]), .halted(halted[0]),
        .fetch_count(fetch_count[0])
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) u_top (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .imem_addr(imem_addr[1]),
        .imem_rdata(imem_rdata[1]), .ifid_pc(ifid_pc[1]), .ifid_pc4(ifid_pc4[1]),
        .ifid_instr(ifid_instr[1]), .ifid_valid(ifid_valid[1]), .halted(halted[1]),
        .fetch_count(fetch_count[1])
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc    [2];
    logic [31:0] m_ipc   [2];
    logic [31:0] m_ipc4  [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_halt  [2];
    logic [31:0] m_cnt   [2];
    bit          model_live = 1'b0;

    function automatic logic [31:0] reset_pc_of(int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = reset_pc_of(k);
                m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = 32'h13;
                m_valid[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
            end else if (!m_halt[k]) begin
                if (branch_taken) begin
                    m_pc[k] = {branch_target[31:2], 2'b00};
                    m_instr[k] = 32'h13; m_valid[k] = 0;
                end else if (halt_req) begin
                    m_halt[k] = 1; m_instr[k] = 32'h13; m_valid[k] = 0;
                end else if (!stall) begin
                    m_ipc[k] = m_pc[k];
                    m_ipc4[k] = m_pc[k] + 4;
                    m_instr[k] = m_pc[k] + 32'h100;
                    m_valid[k] = 1;
                    m_pc[k] = m_pc[k] + 4;
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
        if (rst) model_live = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("imem_addr[%0d]", k), imem_addr[k], m_pc[k]);
                chk($sformatf("ifid_pc[%0d]", k), ifid_pc[k], m_ipc[k]);
                chk($sformatf("ifid_pc4[%0d]", k), ifid_pc4[k], m_ipc4[k]);
                chk($sformatf("ifid_instr[%0d]", k), ifid_instr[k], m_instr[k]);
                chk($sformatf("ifid_valid[%0d]", k), {31'd0, ifid_valid[k]}, {31'd0, m_valid[k]});
                chk($sformatf("halted[%0d]", k), {31'd0, halted[k]}, {31'd0, m_halt[k]});
                chk($sformatf("fetch_count[%0d]", k), fetch_count[k], m_cnt[k]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic h);
        @(negedge clk);
        #1;
        rst = r; stall = s; branch_taken = b; branch_target = t; halt_req = h;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        // Reset for two cycles.
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        chk("rst imem_addr", imem_addr[0], 32'h0);
        chk("rst ifid_instr", ifid_instr[0], 32'h13);
        chk("rst ifid_valid", {31'd0, ifid_valid[0]}, 32'd0);
        chk("rst fetch_count", fetch_count[0], 32'd0);
        chk("rst top imem_addr", imem_addr[1], 32'hFFFF_FFF8);

        // Sequential fetch.
        idle();
        chk("seq0 ifid_pc", ifid_pc[0], 32'h0);
        chk("seq0 ifid_instr", ifid_instr[0], 32'h100);
        chk("seq0 ifid_valid", {31'd0, ifid_valid[0]}, 32'd1);
        chk("top seq0 imem_addr", imem_addr[1], 32'hFFFF_FFFC);
        idle();
        chk("seq1 ifid_pc", ifid_pc[0], 32'h4);
        chk("seq1 ifid_instr", ifid_instr[0], 32'h104);
        chk("top wrap imem_addr", imem_addr[1], 32'h0);
        chk("top wrap ifid_pc4", ifid_pc4[1], 32'h0);

        // Stall three cycles at pc=0x8.
        repeat (3) step(0, 1, 0, 32'h0, 0);
        chk("stall imem_addr", imem_addr[0], 32'h8);
        chk("stall ifid_pc", ifid_pc[0], 32'h4);
        chk("stall fetch_count", fetch_count[0], 32'd2);
        idle();
        chk("resume ifid_pc", ifid_pc[0], 32'h8);
        chk("resume ifid_instr", ifid_instr[0], 32'h108);
        chk("resume fetch_count", fetch_count[0], 32'd3);

        // Branch overrides stall; target low bits dropped.
        step(0, 1, 1, 32'h43, 0);
        chk("br imem_addr", imem_addr[0], 32'h40);
        chk("br ifid_valid", {31'd0, ifid_valid[0]}, 32'd0);
        chk("br ifid_instr", ifid_instr[0], 32'h13);

        // Halt at pc=0x10, then a branch must be ignored.
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 0, 32'h0, 1);
        chk("halt halted", {31'd0, halted[0]}, 32'd1);
        chk("halt imem_addr", imem_addr[0], 32'h10);
        chk("halt ifid_valid", {31'd0, ifid_valid[0]}, 32'd0);
        step(0, 0, 1, 32'h80, 0);
        chk("halted br ignored", imem_addr[0], 32'h10);
        chk("halted stays", {31'd0, halted[0]}, 32'd1);

        // Halt and branch together: branch wins.
        step(1, 0, 0, 32'h0, 0);
        idle();
        step(0, 0, 1, 32'h80, 1);
        chk("hb halted", {31'd0, halted[0]}, 32'd0);
        chk("hb imem_addr", imem_addr[0], 32'h80);
        chk("hb ifid_valid", {31'd0, ifid_valid[0]}, 32'd0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom(),
                 ($urandom_range(0, 59) == 0));
        end

        // Reset mid-run returns every output to its reset value.
        repeat (5) idle();
        step(1, 0, 0, 32'h0, 0);
        chk("midrst imem_addr", imem_addr[0], 32'h0);
        chk("midrst ifid_pc", ifid_pc[0], 32'h0);
        chk("midrst ifid_pc4", ifid_pc4[0], 32'h0);
        chk("midrst ifid_instr", ifid_instr[0], 32'h13);
        chk("midrst halted", {31'd0, halted[0]}, 32'd0);
        chk("midrst fetch_count", fetch_count[0], 32'd0);
        chk("midrst top imem_addr", imem_addr[1], 32'hFFFF_FFF8);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
